// File: rtl/teclado_pkg.sv
// Shared keypad-scanner types: FSM states, 7-segment codes (active-low, bit6=a..bit0=g),
// the (row,col) key map, and timing defaults including the key-repeat intervals.
package teclado_pkg;

    typedef enum logic [1:0] {ESCANEO, REBOTE, EMITIR, SUELTA} estado_t;

    localparam int DEBOUNCE_DEF = 20;
    localparam int REP_PRIMERA  = 500;
    localparam int REP_PERIODO  = 200;

    localparam logic [6:0] SEG_0      = 7'b0000001;
    localparam logic [6:0] SEG_1      = 7'b1001111;
    localparam logic [6:0] SEG_2      = 7'b0010010;
    localparam logic [6:0] SEG_3      = 7'b0000110;
    localparam logic [6:0] SEG_4      = 7'b1001100;
    localparam logic [6:0] SEG_5      = 7'b0100100;
    localparam logic [6:0] SEG_6      = 7'b0100000;
    localparam logic [6:0] SEG_7      = 7'b0001111;
    localparam logic [6:0] SEG_8      = 7'b0000000;
    localparam logic [6:0] SEG_9      = 7'b0000100;
    localparam logic [6:0] SEG_MAS    = 7'b1101100;
    localparam logic [6:0] SEG_MENOS  = 7'b1111110;
    localparam logic [6:0] SEG_IGUAL  = 7'b1110110;
    localparam logic [6:0] SEG_POR    = 7'b1001000;
    localparam logic [6:0] SEG_DIV    = 7'b1011010;
    localparam logic [6:0] SEG_C      = 7'b0110001;
    localparam logic [6:0] SEG_BLANCO = 7'b1111111;

    typedef struct packed {
        logic [6:0] seg;
        logic       digito;
    } tecla_t;

    // Key map: r0: 1 2 3 +; r1: 4 5 6 -; r2: 7 8 9 x; r3: C 0 = /
    function automatic tecla_t mapa_tecla(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return '{SEG_1, 1'b1};
            4'h1: return '{SEG_2, 1'b1};
            4'h2: return '{SEG_3, 1'b1};
            4'h3: return '{SEG_MAS, 1'b0};
            4'h4: return '{SEG_4, 1'b1};
            4'h5: return '{SEG_5, 1'b1};
            4'h6: return '{SEG_6, 1'b1};
            4'h7: return '{SEG_MENOS, 1'b0};
            4'h8: return '{SEG_7, 1'b1};
            4'h9: return '{SEG_8, 1'b1};
            4'hA: return '{SEG_9, 1'b1};
            4'hB: return '{SEG_POR, 1'b0};
            4'hC: return '{SEG_C, 1'b0};
            4'hD: return '{SEG_0, 1'b1};
            4'hE: return '{SEG_IGUAL, 1'b0};
            default: return '{SEG_DIV, 1'b0};
        endcase
    endfunction

    function automatic logic [1:0] primera_fila(input logic [3:0] f);
        if (!f[0]) return 2'd0;
        if (!f[1]) return 2'd1;
        if (!f[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/escaner_teclado_sincronizador.sv
// Two-flop synchronizer for the 4 active-low keypad rows; idles high (no key).
module sincronizador (
    input  logic       clk1kHz,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner with debounce and 7-segment encoding of the accepted key.
// Optional auto-repeat while held: define REPETICION_TECLA_EN.
module escaner_teclado
    import teclado_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic       clk1kHz,
    input  logic       rst,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [6:0] CSseg,
    output logic       tipo,
    output logic       tecla_valida
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [3:0]    filas_s;
    estado_t       estado;
    logic [1:0]    c, r, scan_cnt;
    logic [CW-1:0] cnt;
    tecla_t        tecla;

    sincronizador u_sinc (
        .clk1kHz (clk1kHz),
        .rst     (rst),
        .d       (filas),
        .q       (filas_s)
    );

    assign columnas = ~(4'b0001 << c);
    assign tecla    = mapa_tecla(r, c);

`ifdef REPETICION_TECLA_EN
    logic [8:0] hold_cnt;
`endif

    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            estado       <= ESCANEO;
            c            <= 2'd0;
            r            <= 2'd0;
            scan_cnt     <= 2'd0;
            cnt          <= '0;
            CSseg        <= SEG_BLANCO;
            tipo         <= 1'b0;
            tecla_valida <= 1'b0;
`ifdef REPETICION_TECLA_EN
            hold_cnt     <= '0;
`endif
        end else begin
            tecla_valida <= 1'b0;
            case (estado)
                ESCANEO: begin
                    if (scan_cnt == 2'd3) begin
                        scan_cnt <= 2'd0;
                        if (filas_s != 4'hF) begin
                            r      <= primera_fila(filas_s);
                            cnt    <= '0;
                            estado <= REBOTE;
                        end else begin
                            c <= c + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 2'd1;
                    end
                end
                REBOTE: begin
                    if (!filas_s[r]) begin
                        if (cnt == CNT_FIN) begin
                            // Outputs registered here so they appear during EMITIR
                            estado       <= EMITIR;
                            tecla_valida <= 1'b1;
                            CSseg        <= tecla.seg;
                            tipo         <= tecla.digito;
                        end
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    end else begin
                        c        <= c + 2'd1;
                        scan_cnt <= 2'd0;
                        estado   <= ESCANEO;
                    end
                end
                EMITIR: begin
                    cnt    <= '0;
                    estado <= SUELTA;
`ifdef REPETICION_TECLA_EN
                    hold_cnt <= '0;
`endif
                end
                default: begin // SUELTA
                    if (filas_s[r]) begin
                        if (cnt == CNT_FIN) begin
                            c        <= c + 2'd1;
                            scan_cnt <= 2'd0;
                            cnt      <= '0;
                            estado   <= ESCANEO;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
`ifdef REPETICION_TECLA_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        cnt <= '0;
`ifdef REPETICION_TECLA_EN
                        // Rewinding to REP_PRIMERA-REP_PERIODO yields the steady repeat period
                        if (hold_cnt == 9'(REP_PRIMERA - 1)) begin
                            hold_cnt     <= 9'(REP_PRIMERA - REP_PERIODO);
                            tecla_valida <= !(r == 2'd3 && c == 2'd0);
                        end else begin
                            hold_cnt <= hold_cnt + 9'd1;
                        end
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_escaner_teclado.sv
// Directed + randomized bench for escaner_teclado with a behavioural keypad and key table.
module tb_escaner_teclado;
    logic       clk1kHz = 1'b0;
    logic       rst;
    logic [3:0] filas, columnas;
    logic [6:0] CSseg;
    logic       tipo, tecla_valida;

    logic pulsada [4][4];
    int   checks = 0, failures = 0;
    int   cyc = 0;
    int   stb_cyc[$];
    logic [6:0] last_code;
    logic       last_tipo;

    localparam logic [6:0] TABLA [16] = '{
        7'b1001111, 7'b0010010, 7'b0000110, 7'b1101100,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b1111110,
        7'b0001111, 7'b0000000, 7'b0000100, 7'b1001000,
        7'b0110001, 7'b0000001, 7'b1110110, 7'b1011010};

    escaner_teclado #(.DEBOUNCE(20)) dut (
        .clk1kHz      (clk1kHz),
        .rst          (rst),
        .filas        (filas),
        .columnas     (columnas),
        .CSseg        (CSseg),
        .tipo         (tipo),
        .tecla_valida (tecla_valida)
    );

    always #5 clk1kHz = ~clk1kHz;

    // Passive keypad: a pressed key shorts its row to the driven-low column
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pulsada[r][c] && columnas[c] === 1'b0) filas[r] = 1'b0;
    end

    function automatic logic es_digito(input int r, input int c);
        return (r < 3 && c < 3) || (r == 3 && c == 1);
    endfunction

    task automatic tick();
        @(posedge clk1kHz);
        #1;
        cyc++;
        if (tecla_valida === 1'b1) begin
            stb_cyc.push_back(cyc);
            last_code = CSseg;
            last_tipo = tipo;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic soltar_todo();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pulsada[r][c] = 1'b0;
    endtask

    task automatic chk_tecla(input string tag, input int r, input int c);
        chk({tag, "_seg"}, 32'(last_code), 32'(TABLA[r*4+c]));
        chk({tag, "_tipo"}, 32'(last_tipo), 32'(es_digito(r, c)));
    endtask

    initial begin
        int base, p, run, lat, k, dur;
        soltar_todo();
        rst = 1'b1;
        ticks(3);
        chk("rst_columnas", 32'(columnas), 32'hE);
        chk("rst_cseg", 32'(CSseg), 32'h7F);
        chk("rst_tipo", 32'(tipo), 32'h0);
        chk("rst_strobe", 32'(tecla_valida), 32'h0);
        rst = 1'b0;

        // Idle scan: each column low for 4 cycles in order
        for (int i = 0; i < 100; i++) begin
            chk("idle_columnas", 32'(columnas), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
            tick();
        end
        chk("idle_strobes", 32'(stb_cyc.size()), 0);
        chk("idle_cseg", 32'(CSseg), 32'h7F);

        // Key "7"
        base = stb_cyc.size(); p = cyc;
        pulsada[2][0] = 1'b1; ticks(60); soltar_todo(); ticks(45);
        chk("k7_count", 32'(stb_cyc.size() - base), 1);
        if (stb_cyc.size() > base) begin
            lat = stb_cyc[base] - p;
            chk("k7_latency_le39", 32'(lat <= 39), 1);
        end
        chk_tecla("k7", 2, 0);

        // "=" with bounce bursts, then stable
        base = stb_cyc.size();
        for (int b = 0; b < 3; b++) begin
            pulsada[3][2] = 1'b1; ticks(5); pulsada[3][2] = 1'b0; ticks(5);
        end
        pulsada[3][2] = 1'b1; ticks(60); soltar_todo(); ticks(45);
        chk("igual_count", 32'(stb_cyc.size() - base), 1);
        chk_tecla("igual", 3, 2);

        // Lone 10-cycle glitch
        base = stb_cyc.size();
        pulsada[3][2] = 1'b1; ticks(10); soltar_todo(); ticks(45);
        chk("glitch_count", 32'(stb_cyc.size() - base), 0);

        // "3" and "-" together
        base = stb_cyc.size();
        pulsada[0][2] = 1'b1; pulsada[1][3] = 1'b1; ticks(60);
        chk("sim_count", 32'(stb_cyc.size() - base), 1);
        chk_tecla("sim3", 0, 2);
        pulsada[0][2] = 1'b0; ticks(15);
        chk("sim_menos_blocked", 32'(stb_cyc.size() - base), 1);
        ticks(60);
        chk("sim_menos_count", 32'(stb_cyc.size() - base), 2);
        chk_tecla("sim_menos", 1, 3);
        soltar_todo(); ticks(45);

        // Reset ~10 cycles into debounce of "5"
        base = stb_cyc.size(); run = 0;
        pulsada[1][1] = 1'b1;
        for (int i = 0; i < 100 && run < 5; i++) begin
            tick();
            run = (columnas == 4'b1101) ? run + 1 : 0;
        end
        chk("k5_reached_rebote", 32'(run >= 5), 1);
        ticks(9);
        rst = 1'b1; soltar_todo(); tick();
        chk("k5_rst_columnas", 32'(columnas), 32'hE);
        chk("k5_rst_cseg", 32'(CSseg), 32'h7F);
        chk("k5_rst_tipo", 32'(tipo), 32'h0);
        chk("k5_rst_strobe", 32'(tecla_valida), 32'h0);
        rst = 1'b0; ticks(60);
        chk("k5_no_strobe", 32'(stb_cyc.size() - base), 0);

        // Randomized single presses
        for (int t = 0; t < 10; t++) begin
            k = $urandom_range(0, 15);
            dur = $urandom_range(45, 80);
            base = stb_cyc.size(); p = cyc;
            pulsada[k/4][k%4] = 1'b1; ticks(dur); soltar_todo();
            ticks($urandom_range(45, 60));
            chk("rnd_count", 32'(stb_cyc.size() - base), 1);
            if (stb_cyc.size() > base)
                chk("rnd_latency_le39", 32'((stb_cyc[base] - p) <= 39), 1);
            chk_tecla("rnd", k / 4, k % 4);
            // Short random glitch must never strobe
            base = stb_cyc.size();
            pulsada[k/4][k%4] = 1'b1; ticks($urandom_range(1, 19)); soltar_todo(); ticks(45);
            chk("rnd_glitch", 32'(stb_cyc.size() - base), 0);
        end

        // Hold "+" for 1000 cycles
        base = stb_cyc.size();
        pulsada[0][3] = 1'b1; ticks(1000); soltar_todo(); ticks(45);
`ifdef REPETICION_TECLA_EN
        chk("mas_rep_count", 32'(stb_cyc.size() - base), 4);
        if (stb_cyc.size() == base + 4) begin
            chk("mas_rep_first", 32'((stb_cyc[base+1] - stb_cyc[base]) >= 495 &&
                                     (stb_cyc[base+1] - stb_cyc[base]) <= 505), 1);
            chk("mas_rep_gap2", 32'(stb_cyc[base+2] - stb_cyc[base+1]), 200);
            chk("mas_rep_gap3", 32'(stb_cyc[base+3] - stb_cyc[base+2]), 200);
        end
`else
        chk("mas_hold_count", 32'(stb_cyc.size() - base), 1);
`endif
        chk_tecla("mas", 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 Parameter: DEBOUNCE, default 20, consecutive clk1kHz cycles a key level must be stable (20 ms).
REQ-002 clk1kHz  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 filas  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk1kHz.
REQ-005 columnas  output  4  keypad column drive, one-hot active-low.
REQ-006 CSseg  output  7  seven-segment code of last accepted key, active-low, bit6=a ... bit0=g.
REQ-007 tipo  output  1  1 = digit key, 0 = sign/operator/equals/clear key.
REQ-008 tecla_valida  output  1  one-cycle strobe, CSseg/tipo valid in the same cycle.

Function
REQ-009 filas SHALL pass through a two-flop synchronizer; all decisions use the synchronized value filas_s.
REQ-010 Key map (row,col): r0: 1 2 3 +; r1: 4 5 6 -; r2: 7 8 9 x; r3: C 0 = /; digits SHALL set tipo=1, all others tipo=0.
REQ-011 Codes: digits 0-9 = 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100; + = 1101100; - = 1111110; = = 1110110; x = 1001000; / = 1011010; C = 0110001; idle/blank = 1111111.
REQ-012 FSM states: ESCANEO, REBOTE, EMITIR, SUELTA.
REQ-013 ESCANEO: drive column c (columnas = ~(1<<c)) for 4 cycles; on 4th cycle, if any filas_s bit low, latch c and lowest-index low row r, go REBOTE; else c = c+1 mod 4.
REQ-014 REBOTE: hold column c; count cycles with filas_s[r]==0; reaching DEBOUNCE SHALL go EMITIR; any cycle with filas_s[r]==1 SHALL abandon, c = c+1 mod 4, go ESCANEO.
REQ-015 EMITIR: one cycle; tecla_valida=1, CSseg/tipo updated to map(r,c) in that same cycle; next state SUELTA.
REQ-016 SUELTA: hold column c; count consecutive cycles with filas_s[r]==1, reset count on any 0; reaching DEBOUNCE SHALL go ESCANEO with c = c+1 mod 4.
REQ-017 CSseg/tipo SHALL hold the last emitted value until the next EMITIR.
REQ-018 Simultaneous keys: only one key per press cycle; lowest column scanned first, lowest row within column; other keys ignored until release of the accepted key.
REQ-019 Glitch shorter than DEBOUNCE cycles SHALL never produce tecla_valida.
REQ-020 Latency: stable press to tecla_valida ≤ 16 + 2 + DEBOUNCE + 1 cycles.
REQ-021 Counters SHALL saturate, never wrap.

Reset
REQ-022 rst=1 from any state: state=ESCANEO, c=0, columnas=1110, CSseg=1111111, tipo=0, tecla_valida=0, counters=0, synchronizer=1111.
REQ-023 Reset during REBOTE/SUELTA SHALL discard the pending key with no strobe.

Configuration
REQ-024 Macro REPETICION_TECLA_EN defined: in SUELTA, while key held, re-pulse tecla_valida with same CSseg/tipo after 500 held cycles, then every 200 cycles; digits and operators alike, never C.
REQ-025 Macro undefined: exactly one strobe per press, no hold counter logic present.

Structure
REQ-026 Shared package teclado_pkg: state enum, all 7-seg code constants of REQ-011, key-map table, default DEBOUNCE, repeat constants 500/200.
REQ-027 One sub-module sincronizador (2-flop, 4-bit, reset value 1111); FSM and map in top.

Verification
REQ-028 Reset then idle 100 cycles -> columnas cycles 1110,1101,1011,0111 every 4 cycles, tecla_valida never 1, CSseg=1111111.
REQ-029 Press key "7" (r2,c0) for 60 cycles -> exactly one strobe, CSseg=0001111, tipo=1, within 39 cycles of press.
REQ-030 Press "=" with 5-cycle bounce bursts then stable -> one strobe, CSseg=1110110, tipo=0; 10-cycle glitch alone -> no strobe.
REQ-031 Press "3" and "-" together -> only "3" (0000110) emitted; "-" ignored until "3" released ≥ DEBOUNCE cycles.
REQ-032 rst asserted 10 cycles into REBOTE for "5" -> no strobe, outputs at reset values next cycle.
REQ-033 REPETICION_TECLA_EN defined, hold "+" 1000 cycles -> strobes at ~press+DEBOUNCE, +500, +700, +900; undefined -> single strobe.
